// File: rtl/br_pkg.sv
// Shared encodings for branch resolution: function codes, FSM states, and the
// legal-code helper.
package br_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b010;
  localparam logic [2:0] BR_BGE  = 3'b011;
  localparam logic [2:0] BR_BLTU = 3'b100;
  localparam logic [2:0] BR_BGEU = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;

  // Codes 110 and 111 are reserved; everything up to bgeu is a real branch.
  function automatic logic is_legal_func(input logic [2:0] func);
    return (func <= BR_BGEU);
  endfunction

endpackage

// File: rtl/br_alu.sv
// Combinational branch comparator. Result is x for reserved function codes;
// the caller must mask it.
module br_alu
  import br_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  always_comb begin
    taken = 1'bx;
    case (func)
      BR_BEQ:  taken = (a == b);
      BR_BNE:  taken = (a != b);
      BR_BLT:  taken = ($signed(a) <  $signed(b));
      BR_BGE:  taken = ($signed(a) >= $signed(b));
      BR_BLTU: taken = (a <  b);
      BR_BGEU: taken = (a >= b);
      default: taken = 1'bx;
    endcase
  end

endmodule

// File: rtl/br_resolve_ctrl.sv
// Execute-stage branch resolution: capture, compare, check prediction, redirect
// and flush. Define BR_RESOLVE_STATS_EN to add branch/mispredict counters.
module br_resolve_ctrl
  import br_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  // Handshake: a request transfers on any rising edge where req_valid and
  // req_ready are both high and kill is low; the payload must be stable then.
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_imm,
  input  logic [2:0]      req_func,
  input  logic            req_pred_taken,
  input  logic            kill,
  output logic            resp_valid,
  output logic            resp_taken,
  output logic [XLEN-1:0] resp_target,
  output logic            resp_mispredict,
  output logic            resp_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [1:0]      dbg_state
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  logic [1:0]      state;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic [2:0]      func_q;
  logic            pred_q;
  logic [3:0]      cnt_q;

  logic            alu_taken, legal, taken_eff, mis;
  logic [XLEN-1:0] target, pc_plus4;

  br_alu #(.XLEN(XLEN)) u_alu (
    .func  (func_q),
    .a     (rs1_q),
    .b     (rs2_q),
    .taken (alu_taken)
  );

  // Reserved codes never take, never mispredict.
  assign legal     = is_legal_func(func_q);
  assign taken_eff = legal & alu_taken;
  assign mis       = legal & (taken_eff ^ pred_q);
  assign target    = pc_q + imm_q;
  assign pc_plus4  = pc_q + XLEN'(4);

  assign req_ready = (state == ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      pc_q            <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      imm_q           <= '0;
      func_q          <= '0;
      pred_q          <= 1'b0;
      cnt_q           <= '0;
      resp_valid      <= 1'b0;
      resp_taken      <= 1'b0;
      resp_target     <= '0;
      resp_mispredict <= 1'b0;
      resp_illegal    <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      flush           <= 1'b0;
    end else begin
      resp_valid     <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && !kill) begin
            pc_q   <= req_pc;
            rs1_q  <= req_rs1;
            rs2_q  <= req_rs2;
            imm_q  <= req_imm;
            func_q <= req_func;
            pred_q <= req_pred_taken;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            resp_valid      <= 1'b1;
            resp_taken      <= taken_eff;
            resp_target     <= target;
            resp_mispredict <= mis;
            resp_illegal    <= !legal;
            if (mis) begin
              state          <= ST_REDIR;
              redirect_valid <= 1'b1;
              redirect_pc    <= taken_eff ? target : pc_plus4;
              flush          <= 1'b1;
              cnt_q          <= FLUSH_INIT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_REDIR: begin
          if (kill || cnt_q == 4'd0) begin
            state <= ST_IDLE;
            flush <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  logic count_en;
  assign count_en = (state == ST_EXEC) && !kill && legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (count_en) begin
      if (stat_branches != 32'hFFFF_FFFF)
        stat_branches <= stat_branches + 32'd1;
      if (mis && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Directed bench for br_resolve_ctrl: vector table plus kill/reset sequences.
module tb_br_resolve_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [31:0] req_pc, req_rs1, req_rs2, req_imm;
  logic [2:0]  req_func;
  logic        req_pred_taken, kill;
  logic        resp_valid, resp_taken, resp_mispredict, resp_illegal;
  logic [31:0] resp_target, redirect_pc;
  logic        redirect_valid, flush;
  logic [1:0]  dbg_state;
`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  br_resolve_ctrl #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_pc          (req_pc),
    .req_rs1         (req_rs1),
    .req_rs2         (req_rs2),
    .req_imm         (req_imm),
    .req_func        (req_func),
    .req_pred_taken  (req_pred_taken),
    .kill            (kill),
    .resp_valid      (resp_valid),
    .resp_taken      (resp_taken),
    .resp_target     (resp_target),
    .resp_mispredict (resp_mispredict),
    .resp_illegal    (resp_illegal),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush           (flush),
    .dbg_state       (dbg_state)
`ifdef BR_RESOLVE_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [2:0]  func;
    logic        pred;
    logic        taken, mis, ill;
    logic [31:0] target, rpc;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_pc = v.pc; req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
    req_func = v.func; req_pred_taken = v.pred; req_valid = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] exp_t;
    check($sformatf("v%0d ready_before", idx), {31'd0, req_ready}, 32'd1);
    drive(v);
    exp_q.push_back(v.target);
    @(negedge clk);
    req_valid = 1'b0;
    check($sformatf("v%0d exec_no_resp", idx), {31'd0, resp_valid}, 32'd0);
    check($sformatf("v%0d exec_busy", idx), {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    exp_t = exp_q.pop_front();
    check($sformatf("v%0d resp_valid", idx), {31'd0, resp_valid}, 32'd1);
    check($sformatf("v%0d taken", idx), {31'd0, resp_taken}, {31'd0, v.taken});
    check($sformatf("v%0d target", idx), resp_target, exp_t);
    check($sformatf("v%0d mispredict", idx), {31'd0, resp_mispredict}, {31'd0, v.mis});
    check($sformatf("v%0d illegal", idx), {31'd0, resp_illegal}, {31'd0, v.ill});
    check($sformatf("v%0d redirect_valid", idx), {31'd0, redirect_valid}, {31'd0, v.mis});
    check($sformatf("v%0d flush", idx), {31'd0, flush}, {31'd0, v.mis});
    if (v.mis) begin
      check($sformatf("v%0d redirect_pc", idx), redirect_pc, v.rpc);
      @(negedge clk);
      check($sformatf("v%0d flush_c2", idx), {31'd0, flush}, 32'd1);
      check($sformatf("v%0d redirect_once", idx), {31'd0, redirect_valid}, 32'd0);
      check($sformatf("v%0d redir_busy", idx), {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d flush_done", idx), {31'd0, flush}, 32'd0);
      check($sformatf("v%0d ready_after", idx), {31'd0, req_ready}, 32'd1);
    end else begin
      check($sformatf("v%0d ready_b2b", idx), {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      check($sformatf("v%0d resp_pulse", idx), {31'd0, resp_valid}, 32'd0);
      check($sformatf("v%0d taken_hold", idx), {31'd0, resp_taken}, {31'd0, v.taken});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t kv;

  initial begin
    // pc, rs1, rs2, imm, func, pred, taken, mis, ill, target, redirect_pc
    vecs[0] = '{32'h100, 32'd5, 32'd5, 32'h20, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h120, 32'h0};
    vecs[1] = '{32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 32'h240, 32'h240};
    vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd1, 32'h10, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0};
    vecs[3] = '{32'h300, 32'd1, 32'd1, 32'h8, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 32'h308, 32'h0};
    vecs[4] = '{32'h400, 32'd3, 32'd4, 32'hFFFF_FFF0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3F0, 32'h0};
    vecs[5] = '{32'h500, 32'hFFFF_FFFF, 32'd1, 32'h8, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 32'h508, 32'h0};
    vecs[6] = '{32'h600, 32'hFFFF_FFFF, 32'd1, 32'h100, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 32'h700, 32'h700};
    vecs[7] = '{32'h800, 32'd0, 32'd0, 32'h4, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 32'h804, 32'h0};

    req_valid = 1'b0; kill = 1'b0; req_pc = '0; req_rs1 = '0; req_rs2 = '0;
    req_imm = '0; req_func = '0; req_pred_taken = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst flush", {31'd0, flush}, 32'd0);
    check("rst resp_target", resp_target, 32'd0);
    check("rst redirect_pc", redirect_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Kill during EXEC of a mispredicting bge
    kv = '{32'h900, 32'd5, 32'd1, 32'h40, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 32'h940, 32'h940};
    drive(kv);
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kexec resp_valid", {31'd0, resp_valid}, 32'd0);
    check("kexec redirect", {31'd0, redirect_valid}, 32'd0);
    check("kexec flush", {31'd0, flush}, 32'd0);
    check("kexec ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    check("kexec no_late_resp", {31'd0, resp_valid}, 32'd0);

    // Kill in the first REDIR cycle
    drive(kv);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("kredir redirect", {31'd0, redirect_valid}, 32'd1);
    check("kredir redirect_pc", redirect_pc, 32'h940);
    check("kredir flush_on", {31'd0, flush}, 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kredir flush_off", {31'd0, flush}, 32'd0);
    check("kredir ready", {31'd0, req_ready}, 32'd1);

    // kill together with req_valid in IDLE: nothing captured
    drive(kv);
    kill = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    check("kidle ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    check("kidle no_resp", {31'd0, resp_valid}, 32'd0);

    // Asynchronous reset mid-REDIR
    drive(vecs[1]);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("arst pre_flush", {31'd0, flush}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst flush", {31'd0, flush}, 32'd0);
    check("arst ready", {31'd0, req_ready}, 32'd1);
    check("arst redirect", {31'd0, redirect_valid}, 32'd0);
    check("arst resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst stays_idle", {31'd0, req_ready}, 32'd1);
    check("arst no_pulse", {31'd0, resp_valid}, 32'd0);

`ifdef BR_RESOLVE_STATS_EN
    do_reset();
    run_vec(20, vecs[0]);
    run_vec(21, vecs[1]);
    run_vec(22, vecs[3]);
    run_vec(23, vecs[4]);
    check("stat branches", stat_branches, 32'd3);
    check("stat mispredicts", stat_mispredicts, 32'd1);
    do_reset();
    check("stat branches_rst", stat_branches, 32'd0);
    check("stat mispredicts_rst", stat_mispredicts, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
